// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU op codes, requester IDs and arbiter FSM states.
package calc_pkg;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_MUL = 2'b10;
  localparam logic [1:0] ALU_OP_DIV = 2'b11;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DISP = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way winner select; round-robin on last grant, or req0-first when
// ALU_ARB_FIXED_PRIO_EN is defined. win is meaningless when any is low.
module rr_arbiter2
  import calc_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic any,
  output logic win
);

  assign any = valid0 | valid1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign win = valid0 ? REQ_CORE : REQ_DISP;
`else
  always_comb begin
    win = REQ_CORE;
    if (valid0 && valid1) begin
      win = ~last;
    end else if (valid1) begin
      win = REQ_DISP;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Serializes whole ALU transactions from two requesters (>=3 cycles each plus ALU latency);
// ALU input_ready and requester result_ready stalls hold the FSM. Macro: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_req0_a,
  input  logic [DATA_WIDTH-1:0] i_req0_b,
  input  logic [1:0]            i_req0_op,
  input  logic                  i_req0_signed,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  output logic [DATA_WIDTH-1:0] o_req0_result,
  output logic                  o_req0_error,
  output logic                  o_req0_result_valid,
  input  logic                  i_req0_result_ready,
  input  logic [DATA_WIDTH-1:0] i_req1_a,
  input  logic [DATA_WIDTH-1:0] i_req1_b,
  input  logic [1:0]            i_req1_op,
  input  logic                  i_req1_signed,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  output logic [DATA_WIDTH-1:0] o_req1_result,
  output logic                  o_req1_error,
  output logic                  o_req1_result_valid,
  input  logic                  i_req1_result_ready,
  output logic [DATA_WIDTH-1:0] o_alu_input_a,
  output logic [DATA_WIDTH-1:0] o_alu_input_b,
  output logic [1:0]            o_alu_input_op,
  output logic                  o_alu_input_signed,
  output logic                  o_alu_input_valid,
  input  logic                  i_alu_input_ready,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_error,
  input  logic                  i_alu_result_valid,
  output logic                  o_alu_result_ready
);

  arb_state_t state;
  logic       grant;
  logic       last_grant;
  logic       win;
  logic       any;
  logic       in_idle;
  logic       in_wait;
  logic       to0;
  logic       to1;
  logic       res_hs;

  rr_arbiter2 u_rr (
    .valid0 (i_req0_valid),
    .valid1 (i_req1_valid),
    .last   (last_grant),
    .any    (any),
    .win    (win)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign last_grant = REQ_DISP;
`endif

  // ready is an accept strobe, so it must not fire while reset holds the FSM.
  assign in_idle      = rst_n && (state == IDLE);
  assign o_req0_ready = in_idle && any && (win == REQ_CORE);
  assign o_req1_ready = in_idle && any && (win == REQ_DISP);

  assign in_wait = (state == WAIT_RES);
  assign to0     = in_wait && (grant == REQ_CORE);
  assign to1     = in_wait && (grant == REQ_DISP);

  assign o_req0_result_valid = to0 && i_alu_result_valid;
  assign o_req0_result       = to0 ? i_alu_result : '0;
  assign o_req0_error        = to0 && i_alu_error;
  assign o_req1_result_valid = to1 && i_alu_result_valid;
  assign o_req1_result       = to1 ? i_alu_result : '0;
  assign o_req1_error        = to1 && i_alu_error;

  assign o_alu_result_ready = (to0 && i_req0_result_ready) || (to1 && i_req1_result_ready);
  assign res_hs             = i_alu_result_valid && o_alu_result_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      grant              <= REQ_CORE;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant         <= REQ_DISP;  // "req1 went last" makes req0 win the first tie
`endif
      o_alu_input_a      <= '0;
      o_alu_input_b      <= '0;
      o_alu_input_op     <= '0;
      o_alu_input_signed <= 1'b0;
      o_alu_input_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            o_alu_input_a      <= (win == REQ_DISP) ? i_req1_a      : i_req0_a;
            o_alu_input_b      <= (win == REQ_DISP) ? i_req1_b      : i_req0_b;
            o_alu_input_op     <= (win == REQ_DISP) ? i_req1_op     : i_req0_op;
            o_alu_input_signed <= (win == REQ_DISP) ? i_req1_signed : i_req0_signed;
            o_alu_input_valid  <= 1'b1;
            grant              <= win;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_alu_input_ready) begin
            o_alu_input_valid <= 1'b0;
            state             <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_hs) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= grant;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench: the bench plays both requesters and the ALU and
// predicts grants and routed results from a behavioural arbitration model.
module tb_alu_arbiter;
  import calc_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [W-1:0] ra [2];
  logic [W-1:0] rb [2];
  logic [1:0]   rop [2];
  logic         rsg [2];
  logic         rvld [2];
  logic         rrdy [2];

  logic         ready0, ready1, err0, err1, rv0, rv1;
  logic [W-1:0] res0, res1;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [1:0]   alu_op;
  logic         alu_sg, alu_vld, alu_in_rdy, alu_err, alu_rv, alu_res_rdy;

  int n_chk, n_pass;
  int last_served;
  bit churn_en;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_a(ra[0]), .i_req0_b(rb[0]), .i_req0_op(rop[0]), .i_req0_signed(rsg[0]),
    .i_req0_valid(rvld[0]), .o_req0_ready(ready0), .o_req0_result(res0),
    .o_req0_error(err0), .o_req0_result_valid(rv0), .i_req0_result_ready(rrdy[0]),
    .i_req1_a(ra[1]), .i_req1_b(rb[1]), .i_req1_op(rop[1]), .i_req1_signed(rsg[1]),
    .i_req1_valid(rvld[1]), .o_req1_ready(ready1), .o_req1_result(res1),
    .o_req1_error(err1), .o_req1_result_valid(rv1), .i_req1_result_ready(rrdy[1]),
    .o_alu_input_a(alu_a), .o_alu_input_b(alu_b), .o_alu_input_op(alu_op),
    .o_alu_input_signed(alu_sg), .o_alu_input_valid(alu_vld), .i_alu_input_ready(alu_in_rdy),
    .i_alu_result(alu_res), .i_alu_error(alu_err), .i_alu_result_valid(alu_rv),
    .o_alu_result_ready(alu_res_rdy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Who should win: lone requester, else the one that did not go last (or req0 when fixed).
  function automatic int ref_winner(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last_served;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  // Behaviour of the ALU the bench impersonates; {error, result}.
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op, input logic sg);
    logic [W-1:0] r;
    logic e;
    e = 1'b0;
    case (op)
      ALU_OP_ADD: r = a + b;
      ALU_OP_SUB: r = a - b;
      ALU_OP_MUL: r = a * b;
      default: begin
        if (b == '0) begin
          r = '0;
          e = 1'b1;
        end else if (sg) r = W'($signed(a) / $signed(b));
        else r = a / b;
      end
    endcase
    return {e, r};
  endfunction

  task automatic set_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic sg);
    ra[n] = a; rb[n] = b; rop[n] = op; rsg[n] = sg; rvld[n] = 1'b1;
  endtask

  task automatic new_req(input int n);
    set_req(n, W'($urandom), ($urandom_range(3) == 0) ? '0 : W'($urandom_range(60)),
            2'($urandom), 1'($urandom));
  endtask

  // Requesters come and go (including withdrawing before ready) while the arbiter is busy.
  task automatic churn();
    for (int n = 0; n < 2; n++) begin
      if (rvld[n]) begin
        if ($urandom_range(7) == 0) rvld[n] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        new_req(n);
      end else begin
        ra[n] = W'($urandom);
      end
    end
  endtask

  task automatic check_zero(input string t);
    check({t, "_ctl"}, {ready0, ready1, rv0, rv1, err0, err1, alu_vld, alu_sg, alu_res_rdy}, 0);
    check({t, "_res"}, {res0, res1, alu_op}, 0);
    check({t, "_opnd"}, {alu_a, alu_b}, 0);
  endtask

  // One transaction from accept to result handshake; entered with the arbiter idle.
  task automatic round(input int stall, input int lat, input int rstall, input bit hold,
                       output int won, output logic [W-1:0] got_res, output logic got_err);
    int w;
    logic [W:0] exp;
    logic [W-1:0] ea, eb;
    logic [1:0] eop;
    logic esg;
    got_res = '0;
    got_err = 1'b0;
    @(negedge clk);
    w = ref_winner(rvld[0], rvld[1]);
    check("grant0", ready0, w == 0);
    check("grant1", ready1, w == 1);
    won = ready1 ? 1 : 0;
    ea = ra[w]; eb = rb[w]; eop = rop[w]; esg = rsg[w];
    exp = alu_ref(ea, eb, eop, esg);
    step();
    if (!hold) rvld[w] = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      if (churn_en) churn();
      alu_in_rdy = (i == stall);
      @(negedge clk);
      check("issue_vld", alu_vld, 1);
      check("issue_ab", {alu_a, alu_b}, {ea, eb});
      check("issue_op", {alu_op, alu_sg}, {eop, esg});
      check("issue_quiet", {ready0, ready1, rv0, rv1}, 0);
      step();
    end
    alu_in_rdy = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (churn_en) churn();
      alu_res = W'($urandom);
      @(negedge clk);
      check("wait_quiet", {alu_vld, ready0, ready1, rv0, rv1, alu_res_rdy}, 0);
      step();
    end
    alu_res = exp[W-1:0];
    alu_err = exp[W];
    alu_rv  = 1'b1;
    for (int i = 0; i <= rstall; i++) begin
      rrdy[w]   = (i == rstall);
      rrdy[1-w] = 1'($urandom);
      @(negedge clk);
      check("res_vld", (w == 0) ? {rv0, rv1} : {rv1, rv0}, 2'b10);
      check("res_dat", (w == 0) ? res0 : res1, exp[W-1:0]);
      check("res_err", (w == 0) ? err0 : err1, exp[W]);
      check("other_zero", (w == 0) ? {res1, err1} : {res0, err0}, 0);
      check("alu_res_rdy", alu_res_rdy, i == rstall);
      check("res_quiet", {ready0, ready1, alu_vld}, 0);
      got_res = (w == 0) ? res0 : res1;
      got_err = (w == 0) ? err0 : err1;
      step();
    end
    alu_rv = 1'b0; alu_err = 1'b0; rrdy[0] = 1'b0; rrdy[1] = 1'b0;
    last_served = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int won;
    logic [W-1:0] gr;
    logic ge;
    n_chk = 0; n_pass = 0; last_served = 1; churn_en = 1'b0;
    for (int n = 0; n < 2; n++) begin
      ra[n] = '0; rb[n] = '0; rop[n] = '0; rsg[n] = 1'b0; rvld[n] = 1'b0; rrdy[n] = 1'b0;
    end
    alu_in_rdy = 1'b0; alu_res = '0; alu_err = 1'b0; alu_rv = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    step();
    rst_n = 1'b1;

    // Both valid straight after reset: req0 first, then req1 under backpressure.
    set_req(0, 16'd6, 16'd3, ALU_OP_MUL, 1'b0);
    set_req(1, 16'd123, 16'd10, ALU_OP_DIV, 1'b0);
    round(0, 0, 0, 1'b0, won, gr, ge);
    check("first_won", won, 0);
    check("mul_res", gr, 18);
    round(4, 2, 3, 1'b0, won, gr, ge);
    check("second_won", won, 1);
    check("div_res", gr, 12);

    // Both held valid continuously.
    set_req(0, 16'd100, 16'd23, ALU_OP_ADD, 1'b0);
    set_req(1, 16'd50, 16'd10, ALU_OP_DIV, 1'b0);
    for (int k = 0; k < 4; k++) begin
      round(0, 1, 0, 1'b1, won, gr, ge);
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("held_order", won, 0);
`else
      check("held_order", won, k % 2);
`endif
    end
    rvld[0] = 1'b0; rvld[1] = 1'b0;

    set_req(0, 16'd7, 16'd5, ALU_OP_ADD, 1'b0);
    round(1, 1, 1, 1'b0, won, gr, ge);
    check("add_won", won, 0);
    check("add_res", gr, 12);
    check("add_err", ge, 0);

    set_req(1, 16'd9, 16'd0, ALU_OP_DIV, 1'b0);
    round(0, 2, 1, 1'b0, won, gr, ge);
    check("dz_won", won, 1);
    check("dz_err", ge, 1);
    set_req(0, 16'd1, 16'd1, ALU_OP_ADD, 1'b0);
    round(0, 0, 0, 1'b0, won, gr, ge);
    check("after_dz_res", gr, 2);
    check("after_dz_err", ge, 0);

    // Reset with a result pending in WAIT_RES.
    set_req(0, 16'd11, 16'd22, ALU_OP_SUB, 1'b0);
    step();
    rvld[0] = 1'b0;
    alu_in_rdy = 1'b1;
    step();
    alu_in_rdy = 1'b0; alu_rv = 1'b1; alu_res = 16'h1234;
    @(negedge clk);
    check("pre_reset_rv", rv0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    alu_rv = 1'b0;
    step();
    rst_n = 1'b1;
    last_served = 1;
    set_req(1, 16'd40, 16'd8, ALU_OP_DIV, 1'b0);
    round(1, 1, 1, 1'b0, won, gr, ge);
    check("post_reset_won", won, 1);
    check("post_reset_res", gr, 5);

    // Random traffic with requesters arriving and withdrawing mid-transaction.
    churn_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      if (!rvld[0] && !rvld[1]) new_req($urandom_range(1));
      round($urandom_range(4), $urandom_range(3), $urandom_range(3), 1'b0, won, gr, ge);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
